// File: rtl/alp_muldiv_array.sv
// alp_muldiv_array
// Iterative multiply/divide datapath. The accumulator A and the Q register
// form one double-width shift chain. One add/subtract-and-shift step runs per
// clock under a three-state sequencer (IDLE -> RUN -> DONE) with a start/done
// handshake.
//
// Optional feature macro: ALP_DIV_EN
//   defined   : op 10 runs a restoring unsigned divide.
//   undefined : the divide hardware is compiled out and op 10 behaves as a
//               reserved op (immediate DONE, zero results, v_h=1).
//
// Parameters
//   WIDTH  operand width, multiple of 4, 8..64
//   CNT_W  iteration counter width (derived, leave at default)
//
// Ports
//   qdck_l    in   datapath clock, rising edge
//   rst_h     in   synchronous active-high reset
//   start_h   in   operation request, sampled only in IDLE
//   op_h      in   00 umul, 01 signed Booth mul, 10 udiv, 11 reserved
//   abort_h   in   cancel a running operation
//   a_h       in   multiplicand or divisor
//   b_h       in   multiplier or dividend
//   busy_h    out  high while in RUN
//   done_h    out  one-cycle completion pulse
//   res_hi_h  out  A: product high half or remainder
//   res_lo_h  out  Q: product low half or quotient
//   z_h       out  result-zero flag
//   n_h       out  result-negative flag (signed multiply only)
//   v_h       out  divide by zero or reserved op

module alp_muldiv_array #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             qdck_l,
   input  logic             rst_h,
   input  logic             start_h,
   input  logic [1:0]       op_h,
   input  logic             abort_h,
   input  logic [WIDTH-1:0] a_h,
   input  logic [WIDTH-1:0] b_h,
   output logic             busy_h,
   output logic             done_h,
   output logic [WIDTH-1:0] res_hi_h,
   output logic [WIDTH-1:0] res_lo_h,
   output logic             z_h,
   output logic             n_h,
   output logic             v_h
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [1:0]       OP_UMUL  = 2'b00;
   localparam logic [1:0]       OP_SMUL  = 2'b01;
   localparam logic [1:0]       OP_UDIV  = 2'b10;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] m_q;
   logic             q_m1_q;
   logic             z_q, n_q, v_q;

   logic [WIDTH:0]   acc_d;
   logic [WIDTH-1:0] q_d;
   logic             q_m1_d;
   logic             z_d, n_d;
   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   sum;
   logic             reserved_op;
   logic             div_by_zero;
`ifdef ALP_DIV_EN
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] trial;
`endif

   // Classify the requested operation at the accept point. Reserved ops and
   // divide-by-zero skip RUN and go straight to DONE with a fixed result.
   always_comb begin
      reserved_op = (op_h == 2'b11);
      div_by_zero = 1'b0;
`ifdef ALP_DIV_EN
      div_by_zero = (op_h == OP_UDIV) && (a_h == '0);
`else
      if (op_h == OP_UDIV) begin
         reserved_op = 1'b1;
      end
`endif
   end

   // One iteration of the selected algorithm. acc_q carries a guard bit above
   // A: it is the carry for unsigned multiply and the sign extension for
   // Booth, which keeps -2^(W-1) * -2^(W-1) exact.
   always_comb begin
      acc_d  = acc_q;
      q_d    = q_q;
      q_m1_d = q_m1_q;
      m_ext  = {m_q[WIDTH-1], m_q};
      sum    = acc_q;
`ifdef ALP_DIV_EN
      rem_sh = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      trial  = rem_sh[WIDTH-1:0] - m_q;
`endif
      case (op_q)
         OP_UMUL: begin
            sum    = {1'b0, acc_q[WIDTH-1:0]} + (q_q[0] ? {1'b0, m_q} : '0);
            acc_d  = {1'b0, sum[WIDTH:1]};
            q_d    = {sum[0], q_q[WIDTH-1:1]};
            q_m1_d = 1'b0;
         end
         OP_SMUL: begin
            case ({q_q[0], q_m1_q})
               2'b01:   sum = acc_q + m_ext;
               2'b10:   sum = acc_q - m_ext;
               default: sum = acc_q;
            endcase
            acc_d  = {sum[WIDTH], sum[WIDTH:1]};
            q_d    = {sum[0], q_q[WIDTH-1:1]};
            q_m1_d = q_q[0];
         end
`ifdef ALP_DIV_EN
         // Restoring divide: the partial remainder is always below 2*M after
         // the shift, so the difference fits in WIDTH bits when it is kept.
         OP_UDIV: begin
            if (rem_sh >= {1'b0, m_q}) begin
               acc_d = {1'b0, trial};
               q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {1'b0, rem_sh[WIDTH-1:0]};
               q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
         end
`endif
         default: ;
      endcase
   end

   // Flags for the final step, captured on the edge that enters DONE.
   always_comb begin
      if ((op_q == OP_UMUL) || (op_q == OP_SMUL)) begin
         z_d = ({acc_d[WIDTH-1:0], q_d} == '0);
      end else begin
         z_d = (q_d == '0);
      end
      n_d = (op_q == OP_SMUL) && acc_d[WIDTH-1];
   end

   // Sequencer state register.
   always_ff @(posedge qdck_l) begin
      if (rst_h) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sequencer next state. Abort takes priority over the last iteration.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_h) begin
               state_d = (reserved_op || div_by_zero) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort_h) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath registers. Results and flags hold through DONE and IDLE until
   // the next accepted start.
   always_ff @(posedge qdck_l) begin
      if (rst_h) begin
         cnt_q  <= '0;
         op_q   <= '0;
         acc_q  <= '0;
         q_q    <= '0;
         m_q    <= '0;
         q_m1_q <= 1'b0;
         z_q    <= 1'b0;
         n_q    <= 1'b0;
         v_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_h) begin
                  op_q   <= op_h;
                  m_q    <= a_h;
                  cnt_q  <= CNT_INIT;
                  q_m1_q <= 1'b0;
                  z_q    <= 1'b0;
                  n_q    <= 1'b0;
                  v_q    <= 1'b0;
                  if (reserved_op) begin
                     acc_q <= '0;
                     q_q   <= '0;
                     v_q   <= 1'b1;
                  end else if (div_by_zero) begin
                     acc_q <= {1'b0, b_h};
                     q_q   <= '1;
                     v_q   <= 1'b1;
                  end else begin
                     acc_q <= '0;
                     q_q   <= b_h;
                  end
               end
            end
            ST_RUN: begin
               if (abort_h) begin
                  cnt_q  <= '0;
                  acc_q  <= '0;
                  q_q    <= '0;
                  q_m1_q <= 1'b0;
                  z_q    <= 1'b0;
                  n_q    <= 1'b0;
                  v_q    <= 1'b0;
               end else begin
                  acc_q  <= acc_d;
                  q_q    <= q_d;
                  q_m1_q <= q_m1_d;
                  if (cnt_q == '0) begin
                     z_q <= z_d;
                     n_q <= n_d;
                     v_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_h   = (state_q == ST_RUN);
   assign done_h   = (state_q == ST_DONE);
   assign res_hi_h = acc_q[WIDTH-1:0];
   assign res_lo_h = q_q;
   assign z_h      = z_q;
   assign n_h      = n_q;
   assign v_h      = v_q;

endmodule

// File: tb/tb_alp_muldiv_array.sv
// tb_alp_muldiv_array
// Scoreboard bench for alp_muldiv_array at WIDTH=32. Each issued operation
// pushes its hand-computed result and expected completion cycle; a monitor
// pops and compares whenever done_h is seen. Divide expectations follow the
// ALP_DIV_EN macro.

module tb_alp_muldiv_array;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         z;
      logic         n;
      logic         v;
      logic         chk_z;
      int           done_cyc;
      string        name;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_h = 1'b1;
   logic         start_h = 1'b0;
   logic [1:0]   op_h = 2'b00;
   logic         abort_h = 1'b0;
   logic [W-1:0] a_h = '0;
   logic [W-1:0] b_h = '0;
   logic         busy_h, done_h, z_h, n_h, v_h;
   logic [W-1:0] res_hi_h, res_lo_h;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   alp_muldiv_array #(.WIDTH(W)) dut (
      .qdck_l   (clk),
      .rst_h    (rst_h),
      .start_h  (start_h),
      .op_h     (op_h),
      .abort_h  (abort_h),
      .a_h      (a_h),
      .b_h      (b_h),
      .busy_h   (busy_h),
      .done_h   (done_h),
      .res_hi_h (res_hi_h),
      .res_lo_h (res_lo_h),
      .z_h      (z_h),
      .n_h      (n_h),
      .v_h      (v_h)
   );

   // Free-running clock and edge counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pop the oldest expectation on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (done_h) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_hi"}, 64'(res_hi_h), 64'(e.hi));
            checkOutput({e.name, "_lo"}, 64'(res_lo_h), 64'(e.lo));
            if (e.chk_z) checkOutput({e.name, "_z"}, 64'(z_h), 64'(e.z));
            checkOutput({e.name, "_n"}, 64'(n_h), 64'(e.n));
            checkOutput({e.name, "_v"}, 64'(v_h), 64'(e.v));
            checkOutput({e.name, "_latency"}, 64'(cyc), 64'(e.done_cyc));
         end
      end
   end

   // Issue one operation from an idle DUT and record what must come back.
   // lat is the number of edges after the accepting edge until done_h.
   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] hi, input logic [W-1:0] lo,
                                input logic z, input logic n, input logic v, input logic chk_z,
                                input int lat, input string name);
      exp_t e;
      @(negedge clk);
      op_h    = op;
      a_h     = a;
      b_h     = b;
      start_h = 1'b1;
      e.hi = hi; e.lo = lo; e.z = z; e.n = n; e.v = v; e.chk_z = chk_z;
      e.done_cyc = cyc + 1 + lat;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
      start_h = 1'b0;
      checkOutput({name, "_busy"}, 64'(busy_h), (lat == 0) ? 64'd0 : 64'd1);
   endtask

   // Start an operation that will not complete normally (abort/reset tests).
   task automatic startOnly(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      op_h    = op;
      a_h     = a;
      b_h     = b;
      start_h = 1'b1;
      @(negedge clk);
      start_h = 1'b0;
   endtask

   // Wait, bounded, for every expectation to drain and the DUT to be idle.
   task automatic waitIdle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy_h && !done_h) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_busy"}, 64'(busy_h), 64'd0);
      checkOutput({name, "_done"}, 64'(done_h), 64'd0);
      checkOutput({name, "_hi"}, 64'(res_hi_h), 64'd0);
      checkOutput({name, "_lo"}, 64'(res_lo_h), 64'd0);
      checkOutput({name, "_z"}, 64'(z_h), 64'd0);
      checkOutput({name, "_n"}, 64'(n_h), 64'd0);
      checkOutput({name, "_v"}, 64'(v_h), 64'd0);
   endtask

   // Hard time limit so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst_h = 1'b0;

      // Multiplies
      applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, W, "umul_max");
      waitIdle("umul_max");
      applyStimulus(2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 32'h0626_0060, 1'b0, 1'b0, 1'b0, 1'b1, W, "umul_1234");
      waitIdle("umul_1234");
      applyStimulus(2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, W, "umul_zero");
      waitIdle("umul_zero");
      applyStimulus(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1, 1'b0, 1'b1, W, "smul_m3x5");
      waitIdle("smul_m3x5");
      applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, W, "smul_minmin");
      waitIdle("smul_minmin");
      applyStimulus(2'b01, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b1, 1'b0, 1'b1, W, "smul_7xm1");
      waitIdle("smul_7xm1");

      // Divides
`ifdef ALP_DIV_EN
      applyStimulus(2'b10, 32'd7, 32'd100, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0, 1'b1, W, "div_100_7");
      waitIdle("div_100_7");
      applyStimulus(2'b10, 32'd10, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, W, "div_3_10");
      waitIdle("div_3_10");
      applyStimulus(2'b10, 32'd0, 32'd5, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 0, "div_by_zero");
      waitIdle("div_by_zero");
`else
      applyStimulus(2'b10, 32'd7, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "div_disabled");
      waitIdle("div_disabled");
      applyStimulus(2'b10, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "div0_disabled");
      waitIdle("div0_disabled");
`endif

      // Reserved op
      applyStimulus(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "reserved");
      waitIdle("reserved");

      // Abort mid-operation: no done pulse, A/Q/flags cleared
      startOnly(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(negedge clk);
      abort_h = 1'b1;
      @(negedge clk);
      abort_h = 1'b0;
      checkAllZero("abort");
      repeat (W + 4) @(negedge clk);
      checkOutput("abort_still_idle", 64'(busy_h), 64'd0);

      // Reset mid-operation, then a clean op
      startOnly(2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
      repeat (9) @(negedge clk);
      rst_h = 1'b1;
      @(negedge clk);
      rst_h = 1'b0;
      checkAllZero("midreset");
      applyStimulus(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1, 1'b0, 1'b1, W, "after_reset");
      waitIdle("after_reset");

      // start_h held high: one op per W+2 cycles, operands change before
      // the second accept edge
      begin
         exp_t e1, e2;
         @(negedge clk);
         op_h    = 2'b00;
         a_h     = 32'd3;
         b_h     = 32'd5;
         start_h = 1'b1;
         e1.hi = 32'd0; e1.lo = 32'd15; e1.z = 1'b0; e1.n = 1'b0; e1.v = 1'b0; e1.chk_z = 1'b1;
         e1.done_cyc = cyc + 1 + W;
         e1.name = "held_first";
         e2.hi = 32'd1; e2.lo = 32'd0; e2.z = 1'b0; e2.n = 1'b0; e2.v = 1'b0; e2.chk_z = 1'b1;
         e2.done_cyc = cyc + 1 + (W + 2) + W;
         e2.name = "held_second";
         sb.push_back(e1);
         sb.push_back(e2);
         repeat (W + 2) @(negedge clk);
         a_h = 32'h0001_0000;
         b_h = 32'h0001_0000;
         @(negedge clk);
         start_h = 1'b0;
         checkOutput("held_second_busy", 64'(busy_h), 64'd1);
         waitIdle("held");
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
